// File: rtl/decode_stage_param.sv
// Decode stage: architectural register file plus the decode->execute pipeline register with write-through bypass.
// Latency: one cycle from decode capture to ex_* outputs; register file reads are combinational.
// Backpressure: de_ready drops while execute holds a stalled instruction or a flush is requested; held operands track writeback.
// Optional build macro DECODE_STALL_CNT_EN adds a saturating stall_cnt output that counts decode stall cycles.
module decode_stage_param #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int CTRL_W = 18,
  localparam int REG_AW = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  // decode side
  input  logic              de_valid,
  output logic              de_ready,
  input  logic [31:0]       de_instr,
  input  logic [XLEN-1:0]   de_pc,
  input  logic [XLEN-1:0]   de_pc_plus4,
  input  logic [CTRL_W-1:0] de_ctrl,
  input  logic [XLEN-1:0]   de_imm,
  output logic [REG_AW-1:0] de_rs1,
  output logic [REG_AW-1:0] de_rs2,
  // writeback port
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  // execute side
  input  logic              ex_clear,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_pc_plus_4,
  output logic [XLEN-1:0]   ex_imm_ext,
  output logic [XLEN-1:0]   ex_rd1,
  output logic [XLEN-1:0]   ex_rd2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2
`ifdef DECODE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  // Everything that travels from decode to execute as one registered slot.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_plus_4;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } ex_slot_t;

  logic [XLEN-1:0]   regs [NREGS];
  logic [REG_AW-1:0] rs1_idx;
  logic [REG_AW-1:0] rs2_idx;
  logic [REG_AW-1:0] rd_idx;
  logic [XLEN-1:0]   rd1_val;
  logic [XLEN-1:0]   rd2_val;
  logic              wb_live;
  logic              capture;
  logic              ex_vld_q;
  ex_slot_t          ex_q;
  ex_slot_t          cap_slot;
  logic              instr_unused;

  // Only the low REG_AW bits of each 5-bit register field are meaningful.
  assign rs1_idx = de_instr[11 +: REG_AW];
  assign rs2_idx = de_instr[16 +: REG_AW];
  assign rd_idx  = de_instr[6 +: REG_AW];
  assign instr_unused = ^de_instr;

  assign de_rs1 = rs1_idx;
  assign de_rs2 = rs2_idx;

  // Writes to x0 are architecturally dead, so they never bypass either.
  assign wb_live  = wb_reg_write && (wb_rd != '0);
  assign de_ready = (!ex_vld_q || ex_ready) && !ex_clear;
  assign capture  = de_valid && de_ready;

  // Operand reads: x0 is hard zero, a same-cycle writeback wins over stale array content.
  always_comb begin
    rd1_val = '0;
    rd2_val = '0;
    if (rs1_idx != '0) begin
      rd1_val = (wb_live && (wb_rd == rs1_idx)) ? wb_result : regs[rs1_idx];
    end
    if (rs2_idx != '0) begin
      rd2_val = (wb_live && (wb_rd == rs2_idx)) ? wb_result : regs[rs2_idx];
    end
  end

  // Assemble the slot that a capture would load.
  always_comb begin
    cap_slot           = '0;
    cap_slot.ctrl      = de_ctrl;
    cap_slot.pc        = de_pc;
    cap_slot.pc_plus_4 = de_pc_plus4;
    cap_slot.imm       = de_imm;
    cap_slot.rd1       = rd1_val;
    cap_slot.rd2       = rd2_val;
    cap_slot.rd        = rd_idx;
    cap_slot.rs1       = rs1_idx;
    cap_slot.rs2       = rs2_idx;
  end

  // Register file: single write port, cleared by reset, x0 never written.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_live) begin
      regs[wb_rd] <= wb_result;
    end
  end

  // Pipeline register: flush beats capture beats hold/refresh beats drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_vld_q <= 1'b0;
      ex_q     <= '0;
    end else if (ex_clear) begin
      ex_vld_q <= 1'b0;
      ex_q     <= '0;
    end else if (capture) begin
      ex_vld_q <= 1'b1;
      ex_q     <= cap_slot;
    end else if (ex_vld_q && !ex_ready) begin
      // Stalled slot keeps its fields but picks up results retiring meanwhile.
      if (wb_live && (wb_rd == ex_q.rs1)) begin
        ex_q.rd1 <= wb_result;
      end
      if (wb_live && (wb_rd == ex_q.rs2)) begin
        ex_q.rd2 <= wb_result;
      end
    end else if (ex_vld_q) begin
      // Consumed with nothing behind it: leave a bubble with a zero control word.
      ex_vld_q <= 1'b0;
      ex_q.ctrl <= '0;
    end
  end

  assign ex_valid     = ex_vld_q;
  assign ex_ctrl      = ex_q.ctrl;
  assign ex_pc        = ex_q.pc;
  assign ex_pc_plus_4 = ex_q.pc_plus_4;
  assign ex_imm_ext   = ex_q.imm;
  assign ex_rd1       = ex_q.rd1;
  assign ex_rd2       = ex_q.rd2;
  assign ex_rd        = ex_q.rd;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;

`ifdef DECODE_STALL_CNT_EN
  // Count cycles where decode offers an instruction that is refused; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (de_valid && !de_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage_param.sv
// Bench for decode_stage_param: directed vectors plus a short random stretch.
// A slot-level model tracks expected ex_* state and register contents every cycle.
// Literal expectations at key points pin both the DUT and the model.
module tb_decode_stage_param;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int CTRL_W = 18;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              de_valid, de_ready;
  logic [31:0]       de_instr;
  logic [XLEN-1:0]   de_pc, de_pc_plus4, de_imm;
  logic [CTRL_W-1:0] de_ctrl;
  logic [AW-1:0]     de_rs1, de_rs2;
  logic              wb_reg_write;
  logic [AW-1:0]     wb_rd;
  logic [XLEN-1:0]   wb_result;
  logic              ex_clear, ex_ready, ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [XLEN-1:0]   ex_pc, ex_pc_plus_4, ex_imm_ext, ex_rd1, ex_rd2;
  logic [AW-1:0]     ex_rd, ex_rs1, ex_rs2;
`ifdef DECODE_STALL_CNT_EN
  logic [31:0]       stall_cnt;
`endif

  decode_stage_param #(.XLEN(XLEN), .NREGS(NREGS), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .de_valid(de_valid), .de_ready(de_ready), .de_instr(de_instr),
    .de_pc(de_pc), .de_pc_plus4(de_pc_plus4), .de_ctrl(de_ctrl), .de_imm(de_imm),
    .de_rs1(de_rs1), .de_rs2(de_rs2),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_clear(ex_clear), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_pc_plus_4(ex_pc_plus_4),
    .ex_imm_ext(ex_imm_ext), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2)
`ifdef DECODE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic              armed = 1'b0;
  logic              m_valid;
  logic [CTRL_W-1:0] m_ctrl;
  logic [XLEN-1:0]   m_pc, m_pc4, m_imm, m_rd1, m_rd2;
  logic [AW-1:0]     m_rd, m_rs1, m_rs2;
  logic [XLEN-1:0]   m_regs [NREGS];
  logic [31:0]       m_stall;

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
    if (wb_reg_write && wb_rd == idx) return wb_result;
    return m_regs[idx];
  endfunction

  function automatic logic m_ready();
    return (!m_valid || ex_ready) && !ex_clear;
  endfunction

  always @(posedge clk) begin : model
    logic [AW-1:0]   r1, r2, rdi;
    logic [XLEN-1:0] v1, v2;
    logic            rdy;
    r1  = de_instr[15:11];
    r2  = de_instr[20:16];
    rdi = de_instr[10:6];
    v1  = m_read(r1);
    v2  = m_read(r2);
    rdy = m_ready();
    if (!rst_n) m_stall = 0;
    else if (de_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (!rst_n || ex_clear) begin
      m_valid = 0; m_ctrl = 0; m_pc = 0; m_pc4 = 0; m_imm = 0;
      m_rd1 = 0; m_rd2 = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    end else if (de_valid && rdy) begin
      m_valid = 1; m_ctrl = de_ctrl; m_pc = de_pc; m_pc4 = de_pc_plus4; m_imm = de_imm;
      m_rd1 = v1; m_rd2 = v2; m_rd = rdi; m_rs1 = r1; m_rs2 = r2;
    end else if (m_valid && !ex_ready) begin
      if (wb_reg_write && wb_rd != 0 && wb_rd == m_rs1) m_rd1 = wb_result;
      if (wb_reg_write && wb_rd != 0 && wb_rd == m_rs2) m_rd2 = wb_result;
    end else if (m_valid) begin
      m_valid = 0; m_ctrl = 0;
    end
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
    end else if (wb_reg_write && wb_rd != 0) begin
      m_regs[wb_rd] = wb_result;
    end
    armed = rst_n ? armed : 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("ex_valid", ex_valid, m_valid);
      chk("ex_ctrl", ex_ctrl, m_ctrl);
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_pc_plus_4", ex_pc_plus_4, m_pc4);
      chk("ex_imm_ext", ex_imm_ext, m_imm);
      chk("ex_rd1", ex_rd1, m_rd1);
      chk("ex_rd2", ex_rd2, m_rd2);
      chk("ex_rd", ex_rd, m_rd);
      chk("ex_rs1", ex_rs1, m_rs1);
      chk("ex_rs2", ex_rs2, m_rs2);
      chk("de_ready", de_ready, m_ready());
      chk("de_rs1", de_rs1, de_instr[15:11]);
      chk("de_rs2", de_rs2, de_instr[20:16]);
`ifdef DECODE_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, m_stall);
`endif
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] mk(input int rs1, input int rs2, input int rd);
    logic [31:0] w;
    w = 32'h0000_0033;
    w[15:11] = rs1[4:0];
    w[20:16] = rs2[4:0];
    w[10:6]  = rd[4:0];
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                       input logic [CTRL_W-1:0] ctrl, input logic [XLEN-1:0] imm);
    de_valid = v; de_instr = ins; de_pc = pc; de_pc_plus4 = pc + 4; de_ctrl = ctrl; de_imm = imm;
  endtask

  task automatic wb(input logic en, input logic [AW-1:0] rd, input logic [XLEN-1:0] val);
    wb_reg_write = en; wb_rd = rd; wb_result = val;
  endtask

  initial begin
    rst_n = 0; ex_clear = 0; ex_ready = 1;
    drive(0, 32'h0, 0, 0, 0);
    wb(0, 0, 0);
    step(); step();
    chk("reset ex_valid", ex_valid, 0);
    chk("reset ex_pc", ex_pc, 0);
    chk("reset ex_ctrl", ex_ctrl, 0);
    rst_n = 1;

    // first capture after reset
    drive(1, mk(3, 4, 5), 32'h100, 18'h2A5A5, 32'h10);
    step();
    chk("cap ex_valid", ex_valid, 1);
    chk("cap ex_pc", ex_pc, 32'h100);
    chk("cap ex_pc_plus_4", ex_pc_plus_4, 32'h104);
    chk("cap ex_rd1", ex_rd1, 0);
    chk("cap ex_rd2", ex_rd2, 0);
    chk("cap ex_rd", ex_rd, 5);
    chk("cap ex_ctrl", ex_ctrl, 18'h2A5A5);
    chk("cap ex_imm", ex_imm_ext, 32'h10);

    // same-cycle bypass, then x0 write ignored
    drive(1, mk(3, 0, 6), 32'h104, 18'h1, 32'h0);
    wb(1, 3, 32'hDEAD_BEEF);
    step();
    chk("bypass ex_rd1", ex_rd1, 32'hDEAD_BEEF);
    chk("bypass ex_rd", ex_rd, 6);
    drive(1, mk(0, 3, 7), 32'h108, 18'h2, 32'h0);
    wb(1, 0, 32'h55);
    step();
    chk("x0 ex_rd1", ex_rd1, 0);
    chk("array ex_rd2", ex_rd2, 32'hDEAD_BEEF);

    // hold with refresh
    wb(0, 0, 0);
    drive(1, mk(3, 4, 8), 32'h10C, 18'h00F0F, 32'h4);
    step();
    chk("hold cap ex_pc", ex_pc, 32'h10C);
    ex_ready = 0;
    drive(1, mk(1, 2, 9), 32'h110, 18'h3, 32'h8);
    #1;
    chk("hold de_ready", de_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold ex_pc", ex_pc, 32'h10C);
      chk("hold ex_rd", ex_rd, 8);
      chk("hold ex_valid", ex_valid, 1);
      chk("hold ex_rd2", ex_rd2, 0);
    end
    wb(1, 4, 32'h1234);
    step();
    chk("refresh ex_rd2", ex_rd2, 32'h1234);
    chk("refresh ex_rd1", ex_rd1, 32'hDEAD_BEEF);
    chk("refresh ex_pc", ex_pc, 32'h10C);
    wb(0, 0, 0);
    ex_ready = 1;
    step();
    chk("release ex_pc", ex_pc, 32'h110);
    chk("release ex_rd", ex_rd, 9);

    // flush, then the same instruction is captured
    drive(1, mk(4, 3, 10), 32'h114, 18'h3FFFF, 32'hC);
    ex_clear = 1;
    #1;
    chk("clear de_ready", de_ready, 0);
    step();
    chk("clear ex_valid", ex_valid, 0);
    chk("clear ex_pc", ex_pc, 0);
    chk("clear ex_ctrl", ex_ctrl, 0);
    chk("clear ex_rd1", ex_rd1, 0);
    chk("clear ex_rd", ex_rd, 0);
    ex_clear = 0;
    step();
    chk("recap ex_valid", ex_valid, 1);
    chk("recap ex_pc", ex_pc, 32'h114);
    chk("recap ex_rd1", ex_rd1, 32'h1234);
    chk("recap ex_rd2", ex_rd2, 32'hDEAD_BEEF);
    chk("recap ex_rd", ex_rd, 10);

    // drain
    de_valid = 0;
    step();
    chk("drain ex_valid", ex_valid, 0);
    chk("drain ex_ctrl", ex_ctrl, 0);

    // reset mid-stream discards the writeback
    drive(1, mk(7, 7, 11), 32'h118, 18'h5, 32'h0);
    step();
    rst_n = 0;
    wb(1, 7, 32'h99);
    step();
    chk("midrst ex_valid", ex_valid, 0);
    chk("midrst ex_pc", ex_pc, 0);
    rst_n = 1;
    wb(0, 0, 0);
    drive(1, mk(7, 3, 12), 32'h11C, 18'h6, 32'h0);
    step();
    chk("midrst x7", ex_rd1, 0);
    chk("midrst x3", ex_rd2, 0);

    // mixed traffic checked by the model
    for (int i = 0; i < 80; i++) begin
      drive($urandom_range(0, 3) != 0, mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
            $urandom, $urandom, $urandom);
      ex_ready = $urandom_range(0, 2) != 0;
      ex_clear = $urandom_range(0, 7) == 0;
      wb($urandom_range(0, 1), $urandom_range(0, 7), $urandom);
      step();
    end
    ex_clear = 0;
    wb(0, 0, 0);

`ifdef DECODE_STALL_CNT_EN
    rst_n = 0;
    step();
    chk("stall reset", stall_cnt, 0);
    rst_n = 1;
    ex_ready = 1;
    drive(1, mk(1, 2, 3), 32'h200, 18'h7, 32'h0);
    step();
    ex_ready = 0;
    repeat (5) step();
    chk("stall five", stall_cnt, 5);
    ex_ready = 1;
`endif

    de_valid = 0;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
